tdm_demux: RTL and testbench

Time-division demultiplexer: the receive-side counterpart of the mux-based selection path. It accepts one W-bit sample per valid cycle from a serialized stream in which channels 0..N-1 are interleaved. Using a frame-sync marker, it distributes each sample to its channel register and presents a complete, stable N-channel frame in parallel. It sits between the serial link and the per-channel consumers.

---
 rtl/tdm_pkg.sv | 18 +
 rtl/tdm_slot_counter.sv | 39 +++
 rtl/tdm_demux.sv | 130 +++++++++++++
 tb/tb_tdm_demux.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared types and helpers for the TDM demultiplexer.
package tdm_pkg;

  // Frame alignment state: HUNT waits for a sync marker, RECV is aligned.
  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } tdm_state_e;

  localparam int unsigned DEF_CHANNELS = 4;
  localparam int unsigned DEF_WIDTH    = 8;

  // Slot counter width; this is $clog2(channels), held to at least one bit.
  function automatic int unsigned slot_width(input int unsigned channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot counter for the TDM demultiplexer: counts accepted samples within a frame,
// reloads to 1 on a sync-marked sample and wraps explicitly after CHANNELS-1.
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int unsigned CHANNELS = DEF_CHANNELS,
  parameter int unsigned SLOT_W   = slot_width(CHANNELS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  output logic [SLOT_W-1:0] slot,
  output logic              last
);

  localparam logic [SLOT_W-1:0] LastSlot = SLOT_W'(CHANNELS - 1);

  logic [SLOT_W-1:0] slot_q;

  // Advance on each enabled sample; sync forces slot 1 since the sample itself is slot 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '0;
    end else if (en) begin
      if (load) begin
        slot_q <= SLOT_W'(1);
      end else if (slot_q == LastSlot) begin
        slot_q <= '0;
      end else begin
        slot_q <= slot_q + SLOT_W'(1);
      end
    end
  end

  assign slot = slot_q;
  assign last = (slot_q == LastSlot);

endmodule

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: aligns an interleaved sample stream on a sync
// marker, collects each frame in a shadow bank and publishes it atomically on dout.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int unsigned CHANNELS = DEF_CHANNELS,
  parameter int unsigned WIDTH    = DEF_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          din,
  input  logic                      din_valid,
  input  logic                      sync,
  output logic [CHANNELS*WIDTH-1:0] dout,
  output logic                      dout_valid,
  output logic                      sync_err,
  output logic                      locked
);

  localparam int unsigned SLOT_W = slot_width(CHANNELS);

  tdm_state_e state_q, state_d;

  logic [SLOT_W-1:0]         slot;
  logic                      last;
  logic                      cnt_en;
  logic                      shadow_we;
  logic [SLOT_W-1:0]         shadow_idx;
  logic                      frame_done;
  logic                      err;
  logic [WIDTH-1:0]          shadow_q [CHANNELS];
  logic [CHANNELS*WIDTH-1:0] dout_q, dout_d;
  logic                      dout_valid_q;
  logic                      sync_err_q;

  tdm_slot_counter #(
    .CHANNELS (CHANNELS),
    .SLOT_W   (SLOT_W)
  ) u_slot_counter (
    .clk  (clk),
    .rst  (rst),
    .en   (cnt_en),
    .load (sync),
    .slot (slot),
    .last (last)
  );

  // Framing FSM: decides which samples are stored, when a frame completes and
  // when a framing violation is flagged.
  always_comb begin
    state_d    = state_q;
    cnt_en     = 1'b0;
    shadow_we  = 1'b0;
    shadow_idx = slot;
    frame_done = 1'b0;
    err        = 1'b0;
    unique case (state_q)
      HUNT: begin
        if (din_valid && sync) begin
          shadow_we  = 1'b1;
          shadow_idx = '0;
          cnt_en     = 1'b1;
          state_d    = RECV;
        end
      end
      RECV: begin
        if (din_valid) begin
          if (sync) begin
            // Sync always restarts the frame; mid-frame it also drops the partial frame.
            shadow_we  = 1'b1;
            shadow_idx = '0;
            cnt_en     = 1'b1;
            err        = (slot != '0);
          end else if (slot == '0) begin
            err     = 1'b1;
            state_d = HUNT;
          end else begin
            shadow_we  = 1'b1;
            cnt_en     = 1'b1;
            frame_done = last;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // Next output frame: the stored slots plus the final sample taken straight from din.
  always_comb begin
    dout_d = dout_q;
    if (frame_done) begin
      for (int k = 0; k < CHANNELS - 1; k++) begin
        dout_d[k*WIDTH +: WIDTH] = shadow_q[k];
      end
      dout_d[(CHANNELS-1)*WIDTH +: WIDTH] = din;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HUNT;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      dout_q       <= dout_d;
      dout_valid_q <= frame_done;
      sync_err_q   <= err;
    end
  end

  // Shadow bank holding the frame under construction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < CHANNELS; k++) begin
        shadow_q[k] <= '0;
      end
    end else if (shadow_we) begin
      shadow_q[shadow_idx] <= din;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign sync_err   = sync_err_q;
  assign locked     = (state_q == RECV);

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux (N=4, W=8): directed scenarios plus a
// randomized stream compared against a queue-based frame model.
module tb_tdm_demux;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W-1:0]   din = '0;
  logic           din_valid = 1'b0;
  logic           sync = 1'b0;
  logic [N*W-1:0] dout;
  logic           dout_valid;
  logic           sync_err;
  logic           locked;

  int n_pass = 0;
  int n_total = 0;

  // Reference model state.
  bit             aligned;
  logic [W-1:0]   partial[$];
  logic [N*W-1:0] exp_dout;
  logic           exp_dv;
  logic           exp_err;

  tdm_demux #(
    .CHANNELS (N),
    .WIDTH    (W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .sync       (sync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .sync_err   (sync_err),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    aligned  = 0;
    partial.delete();
    exp_dout = '0;
    exp_dv   = 0;
    exp_err  = 0;
  endtask

  // Frame-level rules: sync starts a frame, a sample with nothing collected
  // and no sync breaks alignment, N collected samples publish a frame.
  task automatic model_accept(input logic s, input logic [W-1:0] d);
    exp_dv  = 0;
    exp_err = 0;
    if (s) begin
      if (aligned && partial.size() != 0) exp_err = 1;
      partial.delete();
      partial.push_back(d);
      aligned = 1;
    end else if (aligned) begin
      if (partial.size() == 0) begin
        exp_err = 1;
        aligned = 0;
      end else begin
        partial.push_back(d);
        if (partial.size() == N) begin
          for (int k = 0; k < N; k++) exp_dout[k*W +: W] = partial[k];
          exp_dv = 1;
          partial.delete();
        end
      end
    end
  endtask

  // One clock cycle of stimulus; outputs are then sampled 1 time unit after the edge.
  task automatic step(input logic v, input logic s, input logic [W-1:0] d);
    @(negedge clk);
    din_valid = v;
    sync      = s;
    din       = d;
    @(posedge clk);
    if (v) model_accept(s, d);
    else begin
      exp_dv  = 0;
      exp_err = 0;
    end
    #1;
  endtask

  task automatic hard_reset();
    @(negedge clk);
    rst = 1'b1;
    din_valid = 1'b0;
    sync = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    hard_reset();
    #1;
    n_total++;
    if (dout !== '0 || dout_valid !== 1'b0 || sync_err !== 1'b0 || locked !== 1'b0)
      $display("FAIL reset: dout=%h dv=%b err=%b locked=%b, want all zero",
               dout, dout_valid, sync_err, locked);
    else n_pass++;
  endtask

  task automatic test_garbage();
    int dv_seen = 0;
    int err_seen = 0;
    int lk_seen = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, W'($urandom));
      dv_seen += int'(dout_valid);
      err_seen += int'(sync_err);
      lk_seen += int'(locked);
    end
    n_total++;
    if (dv_seen != 0 || err_seen != 0 || lk_seen != 0)
      $display("FAIL garbage: dv=%0d err=%0d locked=%0d cycles, want 0/0/0",
               dv_seen, err_seen, lk_seen);
    else n_pass++;
  endtask

  task automatic test_clean();
    logic [W-1:0] seq [8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23};
    int pulse_at[$];
    int err_seen = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, (i % 4) == 0, seq[i]);
      if (dout_valid) pulse_at.push_back(i);
      err_seen += int'(sync_err);
      if (i == 3) begin
        n_total++;
        if (dout !== 32'h13121110)
          $display("FAIL clean_frame1: dout=%h want 13121110", dout);
        else n_pass++;
      end
    end
    n_total++;
    if (dout !== 32'h23222120) $display("FAIL clean_frame2: dout=%h want 23222120", dout);
    else n_pass++;
    n_total++;
    if (pulse_at.size() != 2 || pulse_at[0] != 3 || pulse_at[1] != 7)
      $display("FAIL clean_pulses: got %0d pulses, want 2 at samples 3 and 7",
               pulse_at.size());
    else n_pass++;
    n_total++;
    if (err_seen != 0) $display("FAIL clean_err: sync_err seen %0d, want 0", err_seen);
    else n_pass++;
  endtask

  task automatic test_gaps();
    int pulses = 0;
    int unstable = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, i == 0, W'(8'h10 + i));
      pulses += int'(dout_valid);
      if (i < 3 && dout !== 32'h23222120) unstable++;
      for (int g = 0; g < 3; g++) begin
        step(1'b0, 1'b0, 8'hEE);
        pulses += int'(dout_valid);
        if (i < 3 && dout !== 32'h23222120) unstable++;
        if (i == 3 && dout !== 32'h13121110) unstable++;
      end
    end
    n_total++;
    if (dout !== 32'h13121110) $display("FAIL gaps_dout: dout=%h want 13121110", dout);
    else n_pass++;
    n_total++;
    if (pulses != 1 || unstable != 0)
      $display("FAIL gaps_pulse: pulses=%0d unstable=%0d, want 1 and 0", pulses, unstable);
    else n_pass++;
  endtask

  task automatic test_early_sync();
    logic [W-1:0] seq [6] = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
    logic         sy  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int dv_early = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, sy[i], seq[i]);
      if (i < 5) dv_early += int'(dout_valid);
      if (i == 2) begin
        n_total++;
        if (sync_err !== 1'b1 || locked !== 1'b1)
          $display("FAIL early_err: sync_err=%b locked=%b want 1/1", sync_err, locked);
        else n_pass++;
      end
    end
    n_total++;
    if (dv_early != 0 || dout_valid !== 1'b1 || dout !== 32'hB3B2B1B0)
      $display("FAIL early_frame: early_dv=%0d dv=%b dout=%h want 0/1/b3b2b1b0",
               dv_early, dout_valid, dout);
    else n_pass++;
  endtask

  task automatic test_missing_sync();
    int bad = 0;
    step(1'b1, 1'b0, 8'hC0);
    n_total++;
    if (sync_err !== 1'b1 || locked !== 1'b0)
      $display("FAIL missing_err: sync_err=%b locked=%b want 1/0", sync_err, locked);
    else n_pass++;
    for (int i = 1; i < 4; i++) begin
      step(1'b1, 1'b0, W'(8'hC0 + i));
      if (dout_valid !== 1'b0 || sync_err !== 1'b0 || locked !== 1'b0) bad++;
    end
    n_total++;
    if (bad != 0 || dout !== 32'hB3B2B1B0)
      $display("FAIL missing_hold: bad=%0d dout=%h want 0 and b3b2b1b0", bad, dout);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b1, 8'hD0);
    step(1'b1, 1'b0, 8'hD1);
    @(negedge clk);
    din_valid = 1'b0;
    sync = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_total++;
    if (dout !== '0 || dout_valid !== 1'b0 || sync_err !== 1'b0 || locked !== 1'b0)
      $display("FAIL reset_mid: dout=%h dv=%b err=%b locked=%b, want all zero",
               dout, dout_valid, sync_err, locked);
    else n_pass++;
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, i == 0, W'(i + 1));
    n_total++;
    if (dout !== 32'h04030201 || dout_valid !== 1'b1)
      $display("FAIL reset_frame: dout=%h dv=%b want 04030201/1", dout, dout_valid);
    else n_pass++;
  endtask

  task automatic test_random();
    int errs = 0;
    hard_reset();
    for (int i = 0; i < 400; i++) begin
      logic v = ($urandom_range(0, 3) != 0);
      logic s = ($urandom_range(0, 5) == 0);
      step(v, s, W'($urandom));
      n_total++;
      if (dout !== exp_dout || dout_valid !== exp_dv || sync_err !== exp_err ||
          locked !== aligned) begin
        if (errs < 10)
          $display("FAIL random[%0d]: dout=%h dv=%b err=%b lk=%b want %h %b %b %b", i,
                   dout, dout_valid, sync_err, locked, exp_dout, exp_dv, exp_err, aligned);
        errs++;
      end else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_garbage();
    hard_reset();
    test_clean();
    test_gaps();
    test_early_sync();
    test_missing_sync();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
